// File: rtl/pattern_scan_ctrl.sv
// Serialises each accepted word MSB-first through a bit history, pulsing hit per pattern match
// and reporting a per-word count. Throughput is one word per WORD_W+2 cycles; in_ready is low while busy.
module pattern_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_sof,
  output logic              busy,
  output logic              hit,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);
  localparam logic [PAT_W-1:0] PAT_RST  = PAT_W'(8'h35);
  localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(6);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t              state;
  logic [PAT_W-1:0]    pat_q;
  logic [LEN_W-1:0]    len_q;
  logic [PAT_W-1:0]    hist;
  logic [LEN_W-1:0]    fill;
  logic [WORD_W-1:0]   word_q;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    cnt_acc;

  logic [LEN_W-1:0]    cfg_len_c;
  logic [PAT_W-1:0]    mask;
  logic [PAT_W-1:0]    hist_nxt;
  logic [LEN_W-1:0]    fill_nxt;
  logic                match;
  logic [CNT_W-1:0]    cnt_nxt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // A length of zero or beyond the register width means "use the full width".
  always_comb begin
    cfg_len_c = FULL_LEN;
    if (cfg_len != 4'd0 && 32'(cfg_len) <= 32'(PAT_W))
      cfg_len_c = LEN_W'(cfg_len);
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (i < int'(len_q));
  end

  // Matching looks at the history as it will be after this cycle's bit is shifted in.
  assign hist_nxt = {hist[PAT_W-2:0], word_q[WORD_W-1]};
  assign fill_nxt = (fill == FULL_LEN) ? fill : fill + 1'b1;
  assign match    = ((hist_nxt & mask) == (pat_q & mask)) && (fill_nxt >= len_q);
  assign cnt_nxt  = (match && cnt_acc != '1) ? cnt_acc + 1'b1 : cnt_acc;

  always_ff @(posedge clk) begin
    if (rest) begin
      state     <= IDLE;
      pat_q     <= PAT_RST;
      len_q     <= LEN_RST;
      hist      <= '0;
      fill      <= '0;
      word_q    <= '0;
      bit_cnt   <= '0;
      cnt_acc   <= '0;
      match_cnt <= '0;
      hit       <= 1'b0;
      done      <= 1'b0;
    end else begin
      hit  <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len_c;
            hist  <= '0;
            fill  <= '0;
          end
          if (in_valid) begin
            word_q  <= in_data;
            bit_cnt <= '0;
            cnt_acc <= '0;
            state   <= SHIFT;
            if (in_sof) begin
              hist <= '0;
              fill <= '0;
            end
          end
        end
        SHIFT: begin
          hist    <= hist_nxt;
          fill    <= fill_nxt;
          word_q  <= word_q << 1;
          bit_cnt <= bit_cnt + 1'b1;
          hit     <= match;
          cnt_acc <= cnt_nxt;
          // The final bit's hit is folded into the reported count directly.
          if (bit_cnt == LAST_BIT) begin
            match_cnt <= cnt_nxt;
            done      <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: per-cycle hit/done/ready/busy traces checked against hand-derived vectors.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rest;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sof;
  logic       busy;
  logic       hit;
  logic       done;
  logic [7:0] match_cnt;

  int errors = 0;
  int checks = 0;

  pattern_scan_ctrl #(.WORD_W(8), .PAT_W(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rest        (rest),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .busy        (busy),
    .hit         (hit),
    .done        (done),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    chk({tag, ".ready_wait"}, 32'(in_ready), 32'd1);
  endtask

  // Offers one word at edge E0 and records cycles 1..10 after it (bit c of each trace = cycle c).
  // cfg_cyc = 0 writes config alongside the word; cfg_cyc = n > 0 holds cfg_we during cycle n.
  task automatic run_word(input string tag, input logic [7:0] data, input logic sof,
                          input logic do_cfg, input logic [7:0] pat, input logic [3:0] len,
                          input int cfg_cyc, input logic [15:0] exp_hits, input logic [7:0] exp_cnt);
    logic [15:0] hv, dv, rv, bv;
    logic [7:0]  cnt9;
    hv = '0; dv = '0; rv = '0; bv = '0; cnt9 = '0;
    wait_ready(tag);
    in_valid = 1'b1;
    in_data  = data;
    in_sof   = sof;
    if (do_cfg && cfg_cyc == 0) begin
      cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len;
    end
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      hv[c] = hit;
      dv[c] = done;
      rv[c] = in_ready;
      bv[c] = busy;
      if (c == 9) cnt9 = match_cnt;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      cfg_we   = 1'b0;
      if (do_cfg && cfg_cyc == c) begin
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len;
      end
    end
    cfg_we = 1'b0;
    chk({tag, ".hit"},   32'(hv), 32'(exp_hits));
    chk({tag, ".done"},  32'(dv), 32'h0200);
    chk({tag, ".ready"}, 32'(rv), 32'h0400);
    chk({tag, ".busy"},  32'(bv), 32'h03FE);
    chk({tag, ".cnt"},   32'(cnt9), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rest = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rest = 1'b0;
    @(negedge clk);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.hit",       32'(hit),       32'd0);
    chk("rst.done",      32'(done),      32'd0);
    chk("rst.match_cnt", 32'(match_cnt), 32'd0);

    // Default 110101: D4 = 1101_0100 matches after bit 6.
    run_word("single", 8'hD4, 1'b1, 1'b0, 8'h00, 4'd0, -1, 16'h0080, 8'd1);

    // History carries into the second word: match completes on its 4th bit.
    run_word("cross0", 8'h03, 1'b1, 1'b0, 8'h00, 4'd0, -1, 16'h0000, 8'd0);
    run_word("cross1", 8'h5F, 1'b0, 1'b0, 8'h00, 4'd0, -1, 16'h0020, 8'd1);
    run_word("sof0",   8'h03, 1'b1, 1'b0, 8'h00, 4'd0, -1, 16'h0000, 8'd0);
    run_word("sof1",   8'h5F, 1'b1, 1'b0, 8'h00, 4'd0, -1, 16'h0000, 8'd0);

    // Pattern "11": fill gating suppresses bit 1, then bits 2..8 all hit.
    run_word("overlap", 8'hFF, 1'b1, 1'b1, 8'h03, 4'd2, 0, 16'h03F8, 8'd7);

    // Write during SHIFT is dropped; config stays "11".
    run_word("midcfg",   8'hAA, 1'b1, 1'b1, 8'hAA, 4'd8, 3, 16'h0000, 8'd0);
    run_word("midcfg_a", 8'hFF, 1'b1, 1'b0, 8'h00, 4'd0, -1, 16'h03F8, 8'd7);

    run_word("cfg_same", 8'hAA, 1'b0, 1'b1, 8'hAA, 4'd8,  0, 16'h0200, 8'd1);
    run_word("len0",     8'hAA, 1'b0, 1'b1, 8'hAA, 4'd0,  0, 16'h0200, 8'd1);
    run_word("len15",    8'hAA, 1'b0, 1'b1, 8'hAA, 4'd15, 0, 16'h0200, 8'd1);

    // Reset in cycle 4 of SHIFT.
    wait_ready("midrst");
    in_valid = 1'b1; in_data = 8'hFF; in_sof = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0;
    end
    rest = 1'b1;
    @(negedge clk);
    chk("midrst.in_ready",  32'(in_ready),  32'd1);
    chk("midrst.busy",      32'(busy),      32'd0);
    chk("midrst.done",      32'(done),      32'd0);
    chk("midrst.match_cnt", 32'(match_cnt), 32'd0);
    rest = 1'b0;
    @(negedge clk);
    chk("midrst.ready_after", 32'(in_ready), 32'd1);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("midrst.no_done", 32'(done_seen), 32'd0);

    // Configuration is back to 110101 / len 6.
    run_word("postrst", 8'hD4, 1'b1, 1'b0, 8'h00, 4'd0, -1, 16'h0080, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
